// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port between NUM_REQ burst consumers.
// Latency: grant one cycle after req seen in IDLE; out_valid/out_data one cycle after an accepted read.
// Backpressure: rd_empty stalls the active burst (count held, no timeout); owner dropping req aborts it.
//
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   req, burst_len       : per-requester level request and burst word count (field i at [i*BURST_WIDTH +: BURST_WIDTH])
//   rd_empty, rd_data    : FIFO status and read data (data valid one cycle after an accepted read)
//   rd_ready             : FIFO read strobe, only driver
//   grant, busy          : registered one-hot owner, high while a burst is active
//   out_data, out_valid  : rd_data pass-through tagged with a one-hot owner valid
//   burst_done/abort     : single-cycle completion / early-termination pulses

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_rd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int BURST_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BURST_WIDTH-1:0] burst_len,
    input  logic                           rd_empty,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [NUM_REQ-1:0]             out_valid,
    output logic                           busy,
    output logic                           burst_done,
    output logic                           burst_abort
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                   state, state_nxt;
    logic [NUM_REQ-1:0]       grant_nxt;
    logic [BURST_WIDTH-1:0]   count, count_nxt;
    logic [LW-1:0]            last, last_nxt;
    logic                     done_nxt, abort_nxt;

    logic [LW-1:0]            sel;
    logic                     sel_vld;
    logic [BURST_WIDTH-1:0]   sel_len;
    logic                     owner_req;

    // Round-robin pick: first set req starting just after the previous owner.
    // The modulo is explicit so non-power-of-2 NUM_REQ wraps correctly.
    always_comb begin
        int idx;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel     = LW'(idx);
            end
        end
    end

    assign sel_len = burst_len[int'(sel)*BURST_WIDTH +: BURST_WIDTH];

    // While in XFER, last always holds the current owner index.
    assign owner_req = req[last];
    assign rd_ready  = (state == XFER) && owner_req && !rd_empty;
    assign busy      = (state == XFER);
    assign out_data  = rd_data;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        count_nxt = count;
        last_nxt  = last;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt      = XFER;
                    grant_nxt      = '0;
                    grant_nxt[sel] = 1'b1;
                    last_nxt       = sel;
                    // A zero-length request still moves one word.
                    count_nxt      = (sel_len == '0) ? BURST_WIDTH'(1) : sel_len;
                end
            end
            XFER: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    abort_nxt = 1'b1;
                end else if (rd_ready) begin
                    if (count == BURST_WIDTH'(1)) begin
                        // Leaving at 1 means count never wraps below zero.
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        count_nxt = count - BURST_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            count       <= '0;
            last        <= LW'(NUM_REQ - 1);
            out_valid   <= '0;
            burst_done  <= 1'b0;
            burst_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            count       <= count_nxt;
            last        <= last_nxt;
            // Tag uses the grant of the read cycle, so data after a
            // burst ends is still attributed to the right owner.
            out_valid   <= rd_ready ? grant : '0;
            burst_done  <= done_nxt;
            burst_abort <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios then randomized traffic against a burst-level model.
// Latency: expected words are due one cycle after the model accepts a read.
// Backpressure: FIFO emptiness and owner request drops are randomized.
module tb_fifo_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*BW-1:0] burst_len;
    logic            rd_empty;
    logic [DW-1:0]   rd_data;
    logic            rd_ready;
    logic [N-1:0]    grant;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            burst_done;
    logic            burst_abort;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .burst_len  (burst_len),
        .rd_empty   (rd_empty),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .grant      (grant),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .burst_done (burst_done),
        .burst_abort(burst_abort)
    );

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    logic [DW-1:0] fifo_q[$];
    sb_t           sb_q[$];
    sb_t           mon_e;

    // Burst-level model: who owns the port, words left, last winner, pulses.
    int   m_owner, m_rem, m_last;
    logic m_done, m_abort;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   reads_seen = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] onehot(input int o);
        return (o < 0) ? 32'd0 : (32'd1 << o);
    endfunction

    task automatic set_len(input int i, input int v);
        burst_len[i*BW +: BW] = BW'(v);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    // One clock cycle: check outputs, advance the model, act as the FIFO.
    task automatic step();
        logic exp_rdy, pop, found;
        int   n_owner, n_rem, n_last, len, idx;
        logic n_done, n_abort;
        sb_t  e;
        rd_empty = (fifo_q.size() == 0);
        @(negedge clk);
        exp_rdy = (m_owner >= 0) && req[m_owner] && (fifo_q.size() != 0);
        chk("grant",       32'(grant),       onehot(m_owner));
        chk("rd_ready",    32'(rd_ready),    32'(exp_rdy));
        chk("busy",        32'(busy),        32'(m_owner >= 0));
        chk("burst_done",  32'(burst_done),  32'(m_done));
        chk("burst_abort", 32'(burst_abort), 32'(m_abort));
        pop     = rd_ready && (fifo_q.size() != 0);
        n_owner = m_owner;
        n_rem   = m_rem;
        n_last  = m_last;
        n_done  = 1'b0;
        n_abort = 1'b0;
        if (reset) begin
            n_owner = -1;
            n_rem   = 0;
            n_last  = N - 1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    n_owner = idx;
                    n_last  = idx;
                    len     = int'(burst_len[idx*BW +: BW]);
                    n_rem   = (len == 0) ? 1 : len;
                end
            end
        end else if (!req[m_owner]) begin
            n_owner = -1;
            n_abort = 1'b1;
        end else if (exp_rdy) begin
            e.owner = m_owner;
            e.data  = fifo_q[0];
            e.due   = cyc + 1;
            sb_q.push_back(e);
            reads_seen++;
            n_rem = m_rem - 1;
            if (n_rem == 0) begin
                n_owner = -1;
                n_done  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_owner = n_owner;
        m_rem   = n_rem;
        m_last  = n_last;
        m_done  = n_done;
        m_abort = n_abort;
        if (pop) rd_data = fifo_q.pop_front();
    endtask

    // Monitor: every presented word must match the oldest expected one.
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_valid", 32'(out_valid), onehot(mon_e.owner));
                    chk("out_data",  32'(out_data),  32'(mon_e.data));
                    chk("latency",   32'(cyc),       32'(mon_e.due));
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                chk("missing_out_valid", 32'd0, onehot(mon_e.owner));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        burst_len = '0;
        rd_data   = '0;
        rd_empty  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_owner = -1;
        m_rem   = 0;
        m_last  = N - 1;
        m_done  = 1'b0;
        m_abort = 1'b0;
        chk_en  = 1'b1;
        step();                 // reset state
        reset = 1'b0;

        // 1: single burst of 3 from a 4-word FIFO; D must remain
        fifo_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        req = 4'b0001;
        set_len(0, 3);
        repeat (4) step();
        req = '0;
        repeat (3) step();
        chk("fifo_left_size", 32'(fifo_q.size()), 32'd1);
        if (fifo_q.size() != 0) chk("fifo_left_word", 32'(fifo_q[0]), 32'hD4);

        // 2: two requesters alternate, one IDLE cycle between bursts
        fill(12);
        req = 4'b0101;
        set_len(0, 2);
        set_len(2, 2);
        repeat (12) step();
        req = '0;
        repeat (3) step();

        // 3: burst of 4 with only 2 words available, rest arrive later
        fifo_q.delete();
        fill(2);
        req = 4'b0010;
        set_len(1, 4);
        repeat (6) step();
        fill(1);
        repeat (4) step();
        fill(1);
        repeat (3) step();
        req = '0;
        repeat (3) step();

        // 4: owner 3 drops req after 2 accepted reads
        fill(8);
        req = 4'b1000;
        set_len(3, 5);
        reads_seen = 0;
        for (int t = 0; t < 10 && reads_seen < 2; t++) step();
        chk("abort_setup_reads", 32'(reads_seen), 32'd2);
        req = '0;
        repeat (3) step();

        // 5: zero-length field moves exactly one word
        fill(4);
        req = 4'b0100;
        set_len(2, 0);
        repeat (2) step();
        req = '0;
        repeat (3) step();

        // 6: reset during an accepted read, then all requesters
        fill(8);
        req = 4'b0001;
        set_len(0, 5);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        repeat (4) step();
        req = '0;
        repeat (4) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 16) fill(1);
            for (int i = 0; i < N; i++) begin
                if (i == m_owner) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = ~req[i];
                end
            end
            burst_len = (N*BW)'($urandom);
            step();
        end
        reset = 1'b0;
        req   = '0;
        repeat (20) step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
